// File: rtl/block_mover.sv
// Frame-driven block mover: erases, steps and redraws the active stacker block as a pixel stream.
// Optional feature macro: BLOCK_MOVER_WRAP_EN (wrap to column 0 at the right edge instead of bouncing).
module block_mover #(
  parameter int unsigned BLOCK_W   = 16,
  parameter int unsigned BLOCK_H   = 4,
  parameter int unsigned SCREEN_W  = 160,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_frame,
  input  logic       go,
  input  logic       stop,
  input  logic [6:0] row_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       stopped,
  output logic [7:0] stop_x
);

  localparam logic [7:0] BX_MAX  = 8'(SCREEN_W - BLOCK_W);
  localparam logic [5:0] PX_LAST = 6'(BLOCK_W - 1);
  localparam logic [3:0] PY_LAST = 4'(BLOCK_H - 1);

  typedef enum logic [2:0] {
    IDLE, DRAW, WAIT_FRAME, ERASE, MOVE, LANDED
  } state_t;

  state_t     state, state_n;
  logic [7:0] bx, bx_n;
  logic [6:0] by, by_n;
  logic       dir, dir_n;
  logic [5:0] px, px_n;
  logic [3:0] py, py_n;
  logic       stop_req, stop_req_n;
  logic [7:0] x_n, stop_x_n;
  logic [6:0] y_n;
  logic [2:0] colour_n;
  logic       plot_n, busy_n, stopped_n;
  logic       last_px, last_py;

  assign last_px = (px == PX_LAST);
  assign last_py = (py == PY_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bx       <= '0;
      by       <= '0;
      dir      <= 1'b1;
      px       <= '0;
      py       <= '0;
      stop_req <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      stopped  <= 1'b0;
      stop_x   <= '0;
    end else begin
      state    <= state_n;
      bx       <= bx_n;
      by       <= by_n;
      dir      <= dir_n;
      px       <= px_n;
      py       <= py_n;
      stop_req <= stop_req_n;
      x        <= x_n;
      y        <= y_n;
      colour   <= colour_n;
      plot     <= plot_n;
      busy     <= busy_n;
      stopped  <= stopped_n;
      stop_x   <= stop_x_n;
    end
  end

  always_comb begin
    state_n    = state;
    bx_n       = bx;
    by_n       = by;
    dir_n      = dir;
    px_n       = px;
    py_n       = py;
    stop_req_n = stop_req;
    x_n        = x;
    y_n        = y;
    colour_n   = colour;
    plot_n     = 1'b0;
    busy_n     = busy;
    stopped_n  = stopped;
    stop_x_n   = stop_x;

    case (state)
      IDLE, LANDED: begin
        if (go) begin
          bx_n       = '0;
          by_n       = row_y;
          dir_n      = 1'b1;
          stop_req_n = 1'b0;
          px_n       = '0;
          py_n       = '0;
          busy_n     = 1'b1;
          stopped_n  = 1'b0;
          state_n    = DRAW;
        end
      end

      DRAW, ERASE: begin
        stop_req_n = stop_req | stop;
        x_n        = bx + {2'b00, px};
        y_n        = by + {3'b000, py};
        colour_n   = (state == DRAW) ? FG_COLOUR : BG_COLOUR;
        plot_n     = 1'b1;
        if (last_px) begin
          px_n = '0;
          if (last_py) begin
            py_n    = '0;
            state_n = (state == DRAW) ? WAIT_FRAME : MOVE;
          end else begin
            py_n = py + 4'd1;
          end
        end else begin
          px_n = px + 6'd1;
        end
      end

      WAIT_FRAME: begin
        stop_req_n = stop_req | stop;
        // A stop arriving in this very cycle wins over a simultaneous frame tick.
        if (stop_req | stop) begin
          stop_x_n  = bx;
          busy_n    = 1'b0;
          stopped_n = 1'b1;
          state_n   = LANDED;
        end else if (enable_frame) begin
          state_n = ERASE;
        end
      end

      MOVE: begin
        stop_req_n = stop_req | stop;
`ifdef BLOCK_MOVER_WRAP_EN
        dir_n = 1'b1;
        bx_n  = (bx == BX_MAX) ? '0 : bx + 8'd1;
`else
        if (dir && bx == BX_MAX) begin
          dir_n = 1'b0;
          bx_n  = bx - 8'd1;
        end else if (!dir && bx == '0) begin
          dir_n = 1'b1;
          bx_n  = 8'd1;
        end else begin
          bx_n = dir ? bx + 8'd1 : bx - 8'd1;
        end
`endif
        state_n = DRAW;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_mover.sv
// Self-checking bench for block_mover: directed pass structure with randomized row, idle gaps and
// spurious go/enable_frame pulses, checked against a position-per-frame reference model.
module tb_block_mover;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int SW = 160;
  localparam int BX_MAX = SW - W;
  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable_frame = 1'b0;
  logic       go = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] row_y = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       stopped;
  logic [7:0] stop_x;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;       // frames advanced since the current pass started
  int cur_bx = 0;
  int cur_by = 0;

  block_mover #(
    .BLOCK_W(W), .BLOCK_H(H), .SCREEN_W(SW), .FG_COLOUR(FG), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .reset(reset), .enable_frame(enable_frame), .go(go), .stop(stop),
    .row_y(row_y), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .stopped(stopped), .stop_x(stop_x)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  // Block column after k one-pixel moves from column 0.
  function automatic int exp_bx(input int frames);
`ifdef BLOCK_MOVER_WRAP_EN
    return frames % (BX_MAX + 1);
`else
    int m;
    m = frames % (2 * BX_MAX);
    return (m <= BX_MAX) ? m : 2 * BX_MAX - m;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic burst(input int bx, input int by, input logic [2:0] col, input int stop_at);
    for (int i = 0; i < W * H; i++) begin
      chk("burst_plot", 32'(plot), 1);
      chk("burst_x", 32'(x), 32'(bx + i % W));
      chk("burst_y", 32'(y), 32'(by + i / W));
      chk("burst_colour", 32'(colour), 32'(col));
      enable_frame = (i < W * H - 1) && ($urandom_range(0, 7) == 0);
      stop = (i == stop_at);
      tick();
    end
    enable_frame = 1'b0;
    stop = 1'b0;
  endtask

  task automatic after_draw(input logic landed, input int sx);
    chk("post_plot", 32'(plot), 0);
    chk("post_busy", 32'(busy), landed ? 0 : 1);
    chk("post_stopped", 32'(stopped), landed ? 1 : 0);
    if (landed) chk("post_stop_x", 32'(stop_x), 32'(sx));
  endtask

  task automatic start_pass(input int row);
    go = 1'b1;
    row_y = 7'(row);
    tick();
    go = 1'b0;
    row_y = 7'($urandom_range(0, 124));
    chk("go_plot", 32'(plot), 0);
    chk("go_busy", 32'(busy), 1);
    chk("go_stopped", 32'(stopped), 0);
    tick();
    k = 0;
    cur_bx = 0;
    cur_by = row;
    burst(0, row, FG, -1);
    after_draw(1'b0, 0);
  endtask

  task automatic frame(input int stop_at);
    int pre;
    pre = $urandom_range(0, 3);
    for (int i = 0; i < pre; i++) begin
      go = 1'($urandom_range(0, 1));
      row_y = 7'($urandom_range(0, 124));
      tick();
      chk("wait_plot", 32'(plot), 0);
    end
    go = 1'b0;
    enable_frame = 1'b1;
    tick();
    enable_frame = 1'b0;
    chk("frame_plot", 32'(plot), 0);
    tick();
    burst(cur_bx, cur_by, BG, -1);
    chk("move_plot", 32'(plot), 0);
    tick();
    k++;
    cur_bx = exp_bx(k);
    burst(cur_bx, cur_by, FG, stop_at);
    tick();
    after_draw(stop_at >= 0, cur_bx);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_colour"}, 32'(colour), 0);
    chk({tag, "_plot"}, 32'(plot), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_stopped"}, 32'(stopped), 0);
    chk({tag, "_stop_x"}, 32'(stop_x), 0);
  endtask

  task automatic quiet_landed(input int cycles, input int sx);
    for (int i = 0; i < cycles; i++) begin
      enable_frame = ($urandom_range(0, 3) == 0);
      tick();
      chk("landed_plot", 32'(plot), 0);
      chk("landed_stopped", 32'(stopped), 1);
      chk("landed_busy", 32'(busy), 0);
      chk("landed_stop_x", 32'(stop_x), 32'(sx));
    end
    enable_frame = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    chk("idle_plot", 32'(plot), 0);

    // First pass: draw at column 0, one move, then run to the right edge and beyond
    start_pass(100);
    frame(-1);
    while (k < 145) frame(-1);

    // Reset in the middle of an erase burst
    enable_frame = 1'b1;
    tick();
    enable_frame = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("pre_reset_plot", 32'(plot), 1);
      chk("pre_reset_colour", 32'(colour), 32'(BG));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("midreset");

    // New pass after reset, stop requested mid-draw at column 37
    start_pass($urandom_range(0, 124));
    while (k < 36) frame(-1);
    frame(20);
    quiet_landed(2 * W * H + 4, 37);

    // Restart from LANDED, then stop and frame tick in the same waiting cycle
    start_pass($urandom_range(0, 124));
    frame(-1);
    stop = 1'b1;
    enable_frame = 1'b1;
    tick();
    stop = 1'b0;
    enable_frame = 1'b0;
    chk("same_cycle_plot", 32'(plot), 0);
    chk("same_cycle_stopped", 32'(stopped), 1);
    chk("same_cycle_busy", 32'(busy), 0);
    chk("same_cycle_stop_x", 32'(stop_x), 1);
    quiet_landed(2 * W * H + 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
